// File: rtl/pipe_muxn_pkg.sv
// rtl/pipe_muxn_pkg.sv - shared constants and select-width helper for pipe_muxn.
package pipe_muxn_pkg;

  localparam int MUXN_MAX_IN    = 16;
  localparam int MUXN_DEF_WIDTH = 32;

  // A 2-input selector still needs one select bit, so never return 0.
  function automatic int clog2_min1(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/pipe_muxn_if.sv
// rtl/pipe_muxn_if.sv - data/select/control bundle between a pipeline stage and pipe_muxn.
interface pipe_muxn_if
  import pipe_muxn_pkg::*;
#(
  parameter int WIDTH  = MUXN_DEF_WIDTH,
  parameter int NUM_IN = 4
);

  localparam int SEL_W = clog2_min1(NUM_IN);

  logic [NUM_IN*WIDTH-1:0] d;
  logic [SEL_W-1:0]        sel;
  logic                    in_valid;
  logic                    stall;
  logic                    flush;
  logic [WIDTH-1:0]        y;
  logic                    out_valid;
  logic                    sel_err;

  modport master (
    output d, sel, in_valid, stall, flush,
    input  y, out_valid, sel_err
  );

  modport slave (
    input  d, sel, in_valid, stall, flush,
    output y, out_valid, sel_err
  );

endinterface

// File: rtl/muxn_comb.sv
// rtl/muxn_comb.sv - combinational N:1 select; out-of-range sel yields zero and raises sel_oob.
module muxn_comb
  import pipe_muxn_pkg::*;
#(
  parameter int WIDTH  = MUXN_DEF_WIDTH,
  parameter int NUM_IN = 4
) (
  input  logic [NUM_IN*WIDTH-1:0]      d,
  input  logic [clog2_min1(NUM_IN)-1:0] sel,
  output logic [WIDTH-1:0]             y,
  output logic                         sel_oob
);

  localparam int SEL_W = clog2_min1(NUM_IN);

  // Only legal indices are decoded, so an unused code can never alias onto an input.
  always_comb begin
    y       = '0;
    sel_oob = 1'b1;
    for (int i = 0; i < NUM_IN; i++) begin
      if (sel == SEL_W'(i)) begin
        y       = d[i*WIDTH +: WIDTH];
        sel_oob = 1'b0;
      end
    end
  end

endmodule

// File: rtl/pipe_muxn.sv
// rtl/pipe_muxn.sv - registered N:1 selector with valid, stall and flush control.
// Optional out-of-range select flag and assertion: PIPE_MUXN_SEL_CHECK_EN.
module pipe_muxn
  import pipe_muxn_pkg::*;
#(
  parameter int WIDTH  = MUXN_DEF_WIDTH,
  parameter int NUM_IN = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  pipe_muxn_if.slave bus
);

  logic [WIDTH-1:0] mux_y;
  logic             sel_oob;
  logic [WIDTH-1:0] y_d, y_q;
  logic             out_valid_d, out_valid_q;
  logic             load;

  muxn_comb #(
    .WIDTH  (WIDTH),
    .NUM_IN (NUM_IN)
  ) u_muxn_comb (
    .d       (bus.d),
    .sel     (bus.sel),
    .y       (mux_y),
    .sel_oob (sel_oob)
  );

  assign load = !bus.flush && !bus.stall;

  // Bubbles only drop valid; y keeps its last value to avoid needless toggling.
  always_comb begin
    y_d         = y_q;
    out_valid_d = out_valid_q;
    if (bus.flush) begin
      y_d         = '0;
      out_valid_d = 1'b0;
    end else if (load) begin
      out_valid_d = bus.in_valid;
      if (bus.in_valid) begin
        y_d = mux_y;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      y_q         <= '0;
      out_valid_q <= 1'b0;
    end else begin
      y_q         <= y_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign bus.y         = y_q;
  assign bus.out_valid = out_valid_q;

`ifdef PIPE_MUXN_SEL_CHECK_EN
  logic sel_err_d, sel_err_q;

  always_comb begin
    sel_err_d = sel_err_q;
    if (bus.flush) begin
      sel_err_d = 1'b0;
    end else if (load) begin
      sel_err_d = bus.in_valid && sel_oob;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sel_err_q <= 1'b0;
    end else begin
      sel_err_q <= sel_err_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n && load && bus.in_valid) begin
      assert (!sel_oob);
    end
  end

  assign bus.sel_err = sel_err_q;
`else
  logic unused_sel_oob;
  assign unused_sel_oob = sel_oob;
  assign bus.sel_err    = 1'b0;
`endif

endmodule

// File: tb/tb_pipe_muxn.sv
// tb/tb_pipe_muxn.sv - scoreboard bench for pipe_muxn across four width/count configurations.
module tb_pipe_muxn;

`ifdef PIPE_MUXN_SEL_CHECK_EN
  localparam logic SEL_CHK = 1'b1;
`else
  localparam logic SEL_CHK = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  pipe_muxn_if #(.WIDTH(32), .NUM_IN(4))  if4  ();
  pipe_muxn_if #(.WIDTH(32), .NUM_IN(3))  if3  ();
  pipe_muxn_if #(.WIDTH(1),  .NUM_IN(2))  if2  ();
  pipe_muxn_if #(.WIDTH(64), .NUM_IN(16)) if16 ();

  pipe_muxn #(.WIDTH(32), .NUM_IN(4))  u_dut4  (.clk(clk), .rst_n(rst_n), .bus(if4));
  pipe_muxn #(.WIDTH(32), .NUM_IN(3))  u_dut3  (.clk(clk), .rst_n(rst_n), .bus(if3));
  pipe_muxn #(.WIDTH(1),  .NUM_IN(2))  u_dut2  (.clk(clk), .rst_n(rst_n), .bus(if2));
  pipe_muxn #(.WIDTH(64), .NUM_IN(16)) u_dut16 (.clk(clk), .rst_n(rst_n), .bus(if16));

  typedef struct {
    int          id;
    logic [63:0] y;
    logic        v;
    logic        e;
  } exp_t;

  exp_t        sb[$];
  logic [63:0] my[4];
  logic        mv[4];
  logic        me[4];
  int          errors = 0;
  int          checks = 0;
  string       cur_test = "none";

  function automatic logic [63:0] pick(input logic [1023:0] dflat, input int sel,
                                       input int w, input int n);
    logic [63:0] r;
    r = '0;
    if (sel < n) begin
      for (int b = 0; b < w; b++) r[b] = dflat[sel*w+b];
    end
    return r;
  endfunction

  // Reference register model: reset > flush > stall > load.
  task automatic model(input int id, input logic iv, input logic st, input logic fl,
                       input int sel, input int n, input logic [63:0] dsel);
    exp_t e;
    if (!rst_n) begin
      my[id] = '0; mv[id] = 1'b0; me[id] = 1'b0;
    end else if (fl) begin
      my[id] = '0; mv[id] = 1'b0; me[id] = 1'b0;
    end else if (!st) begin
      if (iv) begin
        mv[id] = 1'b1;
        if (sel < n) begin
          my[id] = dsel; me[id] = 1'b0;
        end else begin
          my[id] = '0; me[id] = SEL_CHK;
        end
      end else begin
        mv[id] = 1'b0; me[id] = 1'b0;
      end
    end
    e.id = id; e.y = my[id]; e.v = mv[id]; e.e = me[id];
    sb.push_back(e);
  endtask

  task automatic cycle();
    exp_t        e;
    logic [63:0] ay;
    logic        av, ae;
    model(0, if4.in_valid, if4.stall, if4.flush, int'(if4.sel), 4,
          pick(1024'(if4.d), int'(if4.sel), 32, 4));
    model(1, if3.in_valid, if3.stall, if3.flush, int'(if3.sel), 3,
          pick(1024'(if3.d), int'(if3.sel), 32, 3));
    model(2, if2.in_valid, if2.stall, if2.flush, int'(if2.sel), 2,
          pick(1024'(if2.d), int'(if2.sel), 1, 2));
    model(3, if16.in_valid, if16.stall, if16.flush, int'(if16.sel), 16,
          pick(if16.d, int'(if16.sel), 64, 16));
    @(posedge clk);
    #1;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      case (e.id)
        0:       begin ay = 64'(if4.y);  av = if4.out_valid;  ae = if4.sel_err;  end
        1:       begin ay = 64'(if3.y);  av = if3.out_valid;  ae = if3.sel_err;  end
        2:       begin ay = 64'(if2.y);  av = if2.out_valid;  ae = if2.sel_err;  end
        default: begin ay = if16.y;      av = if16.out_valid; ae = if16.sel_err; end
      endcase
      checks++;
      if ({ay, av, ae} !== {e.y, e.v, e.e}) begin
        errors++;
        $display("FAIL %s sb dut%0d: got y=%h v=%b e=%b, expected y=%h v=%b e=%b",
                 cur_test, e.id, ay, av, ae, e.y, e.v, e.e);
      end
    end
  endtask

  task automatic idle_all();
    if4.d = '0;  if4.sel = '0;  if4.in_valid = 0;  if4.stall = 0;  if4.flush = 0;
    if3.d = '0;  if3.sel = '0;  if3.in_valid = 0;  if3.stall = 0;  if3.flush = 0;
    if2.d = '0;  if2.sel = '0;  if2.in_valid = 0;  if2.stall = 0;  if2.flush = 0;
    if16.d = '0; if16.sel = '0; if16.in_valid = 0; if16.stall = 0; if16.flush = 0;
  endtask

  task automatic test_reset();
    cur_test = "reset";
    rst_n = 1'b0;
    if4.d = '0; if4.d[63:32] = 32'hDEADBEEF; if4.sel = 2'd1; if4.in_valid = 1'b1;
    for (int k = 0; k < 2; k++) begin
      cycle();
      checks++;
      if ({if4.y, if4.out_valid, if4.sel_err} !== {32'h0, 1'b0, 1'b0}) begin
        errors++;
        $display("FAIL reset_hold: got y=%h v=%b e=%b, expected 0/0/0",
                 if4.y, if4.out_valid, if4.sel_err);
      end
    end
    rst_n = 1'b1;
    cycle();
    checks++;
    if ({if4.y, if4.out_valid} !== {32'hDEADBEEF, 1'b1}) begin
      errors++;
      $display("FAIL reset_first_load: got y=%h v=%b, expected deadbeef/1", if4.y, if4.out_valid);
    end
  endtask

  task automatic test_sweep();
    cur_test = "sweep";
    for (int i = 0; i < 4; i++) if4.d[i*32 +: 32] = 32'h1000_0000 + 32'(i);
    if4.in_valid = 1'b1;
    for (int s = 0; s < 4; s++) begin
      if4.sel = 2'(s);
      cycle();
      checks++;
      if ({if4.y, if4.out_valid} !== {32'h1000_0000 + 32'(s), 1'b1}) begin
        errors++;
        $display("FAIL sweep_sel%0d: got y=%h v=%b, expected %h/1",
                 s, if4.y, if4.out_valid, 32'h1000_0000 + 32'(s));
      end
    end
  endtask

  task automatic test_stall_flush();
    cur_test = "stall_flush";
    if4.d[31:0] = 32'hA5A5A5A5; if4.sel = 2'd0; if4.in_valid = 1'b1;
    cycle();
    if4.stall = 1'b1;
    for (int k = 0; k < 3; k++) begin
      if4.d = {4{32'h0BAD_0000 + 32'(k)}};
      if4.in_valid = k[0];
      cycle();
      checks++;
      if ({if4.y, if4.out_valid} !== {32'hA5A5A5A5, 1'b1}) begin
        errors++;
        $display("FAIL stall_hold%0d: got y=%h v=%b, expected a5a5a5a5/1", k, if4.y, if4.out_valid);
      end
    end
    if4.flush = 1'b1; if4.in_valid = 1'b1;
    cycle();
    checks++;
    if ({if4.y, if4.out_valid} !== {32'h0, 1'b0}) begin
      errors++;
      $display("FAIL flush_over_stall: got y=%h v=%b, expected 0/0", if4.y, if4.out_valid);
    end
    if4.flush = 1'b0; if4.stall = 1'b0;
    if4.d[95:64] = 32'h5555_AAAA; if4.sel = 2'd2;
    cycle();
    checks++;
    if ({if4.y, if4.out_valid} !== {32'h5555_AAAA, 1'b1}) begin
      errors++;
      $display("FAIL stall_release: got y=%h v=%b, expected 5555aaaa/1", if4.y, if4.out_valid);
    end
  endtask

  task automatic test_bubble();
    cur_test = "bubble";
    if4.d[127:96] = 32'h12345678; if4.sel = 2'd3; if4.in_valid = 1'b1;
    cycle();
    if4.in_valid = 1'b0; if4.d = '1;
    cycle();
    checks++;
    if ({if4.y, if4.out_valid} !== {32'h12345678, 1'b0}) begin
      errors++;
      $display("FAIL bubble: got y=%h v=%b, expected 12345678/0", if4.y, if4.out_valid);
    end
  endtask

  task automatic test_oob();
    cur_test = "oob";
    if3.d = {32'h3333_3333, 32'h2222_2222, 32'h1111_1111};
    if3.sel = 2'd3; if3.in_valid = 1'b1;
    cycle();
    checks++;
    if ({if3.y, if3.out_valid, if3.sel_err} !== {32'h0, 1'b1, SEL_CHK}) begin
      errors++;
      $display("FAIL oob_sel3: got y=%h v=%b e=%b, expected 0/1/%b",
               if3.y, if3.out_valid, if3.sel_err, SEL_CHK);
    end
    if3.sel = 2'd0;
    cycle();
    checks++;
    if ({if3.y, if3.out_valid, if3.sel_err} !== {32'h1111_1111, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL oob_recover: got y=%h v=%b e=%b, expected 11111111/1/0",
               if3.y, if3.out_valid, if3.sel_err);
    end
    if3.in_valid = 1'b0;
  endtask

  task automatic test_random();
    cur_test = "random";
    for (int c = 0; c < 10000; c++) begin
      rst_n = ($urandom_range(0, 499) != 0);
      if2.d = 2'($urandom);
      if2.sel = 1'($urandom);
      if2.in_valid = ($urandom_range(0, 3) != 0);
      if2.stall = ($urandom_range(0, 3) == 0);
      if2.flush = ($urandom_range(0, 15) == 0);
      for (int k = 0; k < 32; k++) if16.d[k*32 +: 32] = $urandom;
      if16.sel = 4'($urandom);
      if16.in_valid = ($urandom_range(0, 3) != 0);
      if16.stall = ($urandom_range(0, 3) == 0);
      if16.flush = ($urandom_range(0, 15) == 0);
      if3.d = {$urandom, $urandom, $urandom};
      if3.sel = 2'($urandom);
      if3.in_valid = ($urandom_range(0, 1) != 0);
      if3.stall = ($urandom_range(0, 3) == 0);
      if3.flush = ($urandom_range(0, 15) == 0);
      cycle();
    end
    rst_n = 1'b1;
  endtask

  initial begin
    idle_all();
    test_reset();
    test_sweep();
    test_stall_flush();
    test_bubble();
    test_oob();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pipe_muxn.md
Name: pipe_muxn

Overview:
- Parametrised N:1 data selector with a registered output stage, for pipeline boundaries.
- Typical uses: forwarding/bypass select into EX, writeback source select, PC source select.
- Generalises the 2-input combinational selector in width and input count.
- Adds valid tracking, stall (hold) and flush (bubble) control so the select result is captured directly in a pipeline register.

Parameters:
- WIDTH, 32, data width of each input and of the output.
- NUM_IN, 4, number of data inputs; legal range 2..16.
- SEL_W, derived localparam = max(1, $clog2(NUM_IN)); not overridable.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  reset; synchronous, active-low.
- d  input  NUM_IN*WIDTH  flattened data inputs; input i occupies bits [i*WIDTH +: WIDTH].
- sel  input  SEL_W  binary select index.
- in_valid  input  1  qualifies d/sel this cycle.
- stall  input  1  hold output register.
- flush  input  1  kill output register contents (insert bubble).
- y  output  WIDTH  registered selected data.
- out_valid  output  1  y holds a live value.
- sel_err  output  1  registered out-of-range select flag; present always, function gated by the optional feature.

Behaviour:
- All state updates on the rising edge of clk. No asynchronous paths to the outputs.
- Reset (rst_n=0 at the edge): y=0, out_valid=0, sel_err=0. Reset overrides flush, stall and load.
- Priority when out of reset: flush > stall > load.
- Flush: y<=0, out_valid<=0, sel_err<=0. Applies regardless of stall and in_valid.
- Stall (flush=0): y, out_valid and sel_err hold; d, sel and in_valid are ignored. No input capture, no skid storage.
- Load (flush=0, stall=0):
  - in_valid=1: y<=d[sel], out_valid<=1.
  - in_valid=0: out_valid<=0, y holds its previous value (no toggle on bubbles).
- Latency: exactly 1 cycle from a sampled in_valid=1 to out_valid=1 with the selected data.
- Throughput: 1 item per cycle when stall=0.
- Out-of-range select (sel >= NUM_IN, possible only when NUM_IN is not a power of two), during a load with in_valid=1:
  - y<=0, out_valid<=1.
  - Never X; never aliases onto another input.
- NUM_IN=2 with stall=flush=0 and in_valid=1 is functionally the 2:1 selector delayed one cycle.
- Back-to-back stall cycles: unlimited; the held value is stable for the whole stall.
- Stall released: the next edge loads normally.

Optional Feature:
- Macro: PIPE_MUXN_SEL_CHECK_EN.
- Defined:
  - sel_err<=1 on a load with in_valid=1 and sel>=NUM_IN.
  - sel_err<=0 on a load with any legal sel, or with in_valid=0.
  - sel_err holds on stall and clears on flush/reset.
  - Simulation-only assertion fires the same cycle the illegal sel is sampled.
- Not defined: sel_err is tied to 0 and no check logic is generated. y behaviour is identical in both builds.

Decomposition:
- Package pipe_muxn_pkg:
  - constants MUXN_MAX_IN=16 and MUXN_DEF_WIDTH=32;
  - function clog2_min1 for SEL_W.
- Sub-module muxn_comb (parameters WIDTH, NUM_IN):
  - purely combinational N:1 select;
  - outputs zero for out-of-range sel, plus a combinational sel_oob flag.
- pipe_muxn instantiates muxn_comb and adds the register, valid and control logic.

Test Plan:
- Reset: rst_n=0 for 2 cycles with in_valid=1, sel=1, d1=0xDEADBEEF -> y=0, out_valid=0, sel_err=0 throughout; first load after release -> y=0xDEADBEEF next cycle.
- Sweep: NUM_IN=4, d_i=0x1000_0000+i, sel=0..3 on consecutive cycles with in_valid=1 -> y=0x1000_0000..0x1000_0003 each one cycle later, out_valid=1 continuously.
- Stall/flush priority:
  - load 0xA5A5A5A5, then stall=1 for 3 cycles while d changes -> y stays 0xA5A5A5A5, out_valid=1;
  - then stall=1 and flush=1 together -> y=0, out_valid=0 next cycle.
- Bubble: in_valid=0 after loading 0x12345678 -> out_valid=0, y remains 0x12345678.
- Out-of-range: NUM_IN=3, sel=3, in_valid=1 ->
  - y=0, out_valid=1;
  - sel_err=1 with PIPE_MUXN_SEL_CHECK_EN defined, 0 without;
  - next load with sel=0 -> sel_err=0.
- Width/count corners: WIDTH=1 with NUM_IN=2, and WIDTH=64 with NUM_IN=16, random sel/in_valid/stall/flush for 10k cycles -> matches the cycle-accurate reference model every cycle.
